fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage.sv | 89 ++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch and decode stages.
// Holds the datapath width, the default reset PC and the IF/ID payload.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
        logic            oob;
    } if_id_t;

    // Redirect targets are forced onto a word boundary before they reach memory.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: next-PC selection, PC register and accepted-instruction counter.
// The instruction memory lives outside and returns data one cycle after i_addr.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IMEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] instruction,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misaligned,
    output logic            if_oob,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [XLEN-1:0] IMEM_WORDS_W = XLEN'(IMEM_WORDS);

    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            mis_q;
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] next_addr;
    logic            accept;
    if_id_t          if_id;

    // A stalled entry re-issues its own address so the memory keeps presenting the same word.
    always_comb begin
        next_addr = pc_q;
        if (reset) begin
            next_addr = RESET_PC;
        end else if (redirect_valid) begin
            next_addr = word_align(redirect_pc);
        end else if (valid_q && stall) begin
            next_addr = pc_q;
        end else if (valid_q) begin
            next_addr = pc_q + 32'd4;
        end
    end

    assign i_addr = next_addr;
    assign accept = if_id.valid & ~stall;

    always_comb begin
        if_id            = '0;
        if_id.valid      = valid_q & ~redirect_valid;
        if_id.pc         = pc_q;
        if_id.instr      = instruction;
        if_id.misaligned = mis_q;
        if_id.oob        = valid_q & ({2'b00, pc_q[XLEN-1:2]} >= IMEM_WORDS_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= next_addr;
            valid_q <= 1'b1;
            if (redirect_valid) begin
                mis_q <= |redirect_pc[1:0];
            end else if (valid_q && stall) begin
                mis_q <= mis_q;
            end else begin
                mis_q <= 1'b0;
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign if_valid      = if_id.valid;
    assign if_pc         = if_id.pc;
    assign if_instr      = if_id.instr;
    assign if_misaligned = if_id.misaligned;
    assign if_oob        = if_id.oob;
    assign fetch_count   = count_q;

endmodule
